sine_interp_dds: RTL

//  Parametrised DDS sine generator: 32-bit phase accumulator plus quarter-wave LUT with

---
 rtl/sine_dds_pkg.sv | 39 +++
 rtl/sine_quarter_rom.sv | 29 ++
 rtl/sine_interp_dds.sv | 111 +++++++++++
 3 files changed

// File: rtl/sine_dds_pkg.sv
// rtl/sine_dds_pkg.sv - shared constants and elaboration-time sine table generator for the DDS
package sine_dds_pkg;

    typedef enum logic [1:0] {
        QUAD_0 = 2'd0,
        QUAD_1 = 2'd1,
        QUAD_2 = 2'd2,
        QUAD_3 = 2'd3
    } quadrant_t;

    // pi/2 in Q30, used by the integer Taylor series below
    localparam longint HALF_PI_Q30 = 64'sd1686629713;

    function automatic int sine_amp(input int out_w);
        return (1 << (out_w - 1)) - 1;
    endfunction

    // round(sin(k*pi/2/2^lut_aw) * amp), evaluated in Q30 fixed point so it folds to a constant
    function automatic int sine_lut_entry(input int k, input int lut_aw, input int out_w);
        longint x;
        longint x2;
        longint term;
        longint s;
        longint r;
        x    = (longint'(k) * HALF_PI_Q30) >>> lut_aw;
        x2   = (x * x) >>> 30;
        term = x;
        s    = x;
        for (int n = 1; n <= 8; n++) begin
            term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
            s    = s + term;
        end
        if (s < 0) s = 0;
        r = (s * longint'(sine_amp(out_w)) + (64'sd1 <<< 29)) >>> 30;
        if (r > longint'(sine_amp(out_w))) r = longint'(sine_amp(out_w));
        return int'(r);
    endfunction

endpackage

// File: rtl/sine_quarter_rom.sv
// rtl/sine_quarter_rom.sv - quarter-wave sine ROM, two synchronous read ports
module sine_quarter_rom
    import sine_dds_pkg::*;
#(
    parameter int LUT_AW = 6,
    parameter int OUT_W  = 16
) (
    input  logic              CLK,
    input  logic [LUT_AW:0]   addr_a,
    input  logic [LUT_AW:0]   addr_b,
    output logic [OUT_W-2:0]  data_a,
    output logic [OUT_W-2:0]  data_b
);

    localparam int DEPTH = (1 << LUT_AW) + 1;

    logic [OUT_W-2:0] rom [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        localparam int VAL = sine_lut_entry(k, LUT_AW, OUT_W);
        assign rom[k] = VAL[OUT_W-2:0];
    end

    always_ff @(posedge CLK) begin
        data_a <= rom[addr_a];
        data_b <= rom[addr_b];
    end

endmodule

// File: rtl/sine_interp_dds.sv
// rtl/sine_interp_dds.sv - DDS sine generator with quarter-wave LUT and linear interpolation
module sine_interp_dds
    import sine_dds_pkg::*;
#(
    parameter int PHASE_W    = 32,
    parameter int LUT_AW     = 6,
    parameter int FRAC_W     = 10,
    parameter int OUT_W      = 16,
    parameter bit OFFSET_BIN = 1'b0
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               en,
    input  logic               sync,
    input  logic [PHASE_W-1:0] ftw,
    input  logic [PHASE_W-1:0] phase_ofs,
    output logic [OUT_W-1:0]   out_sine,
    output logic               out_valid
);

    localparam int POS_W = LUT_AW + FRAC_W;
    localparam int KEEP_W = POS_W + 2;
    localparam logic [LUT_AW:0] IDX_MAX = (LUT_AW + 1)'(1) << LUT_AW;
    localparam logic [POS_W:0]  POS_FULL = (POS_W + 1)'(1) << POS_W;

    logic [PHASE_W-1:0]       acc;
    logic                     v1, v2, v3, v4;
    logic [KEEP_W-1:0]        p1;
    quadrant_t                quad1;
    logic [POS_W:0]           pos1, mpos1;
    logic [LUT_AW:0]          idx2, addr_b2;
    logic [FRAC_W-1:0]        f2, f3;
    logic                     neg2, neg3, neg4;
    logic [OUT_W-2:0]         la3, lb3, la4;
    logic signed [OUT_W-1:0]  diff3;
    logic signed [OUT_W+FRAC_W:0] prod4;
    logic signed [OUT_W-1:0]  mag4, y4;
    logic [OUT_W-1:0]         sample4;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            acc       <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            v4        <= 1'b0;
            out_valid <= 1'b0;
            out_sine  <= '0;
        end else begin
            if (sync)    acc <= en ? ftw : '0;
            else if (en) acc <= acc + ftw;
            v1        <= en;
            v2        <= v1;
            v3        <= v2;
            v4        <= v3;
            out_valid <= v4;
            if (v4) out_sine <= sample4;
        end
    end

    // Only the quadrant, index and fraction bits of the phase are carried forward
    always_ff @(posedge CLK) begin
        p1 <= KEEP_W'((sync ? phase_ofs : acc + phase_ofs) >> (PHASE_W - KEEP_W));
    end

    always_comb begin
        quad1 = quadrant_t'(p1[KEEP_W-1 -: 2]);
        pos1  = {1'b0, p1[POS_W-1:0]};
        mpos1 = (quad1 inside {QUAD_1, QUAD_3}) ? POS_FULL - pos1 : pos1;
    end

    always_ff @(posedge CLK) begin
        idx2 <= mpos1[POS_W:FRAC_W];
        f2   <= mpos1[FRAC_W-1:0];
        neg2 <= quad1 inside {QUAD_2, QUAD_3};
    end

    // At the quarter-wave peak the fraction is zero, so the second read just repeats the first
    assign addr_b2 = (idx2 == IDX_MAX) ? idx2 : idx2 + 1'b1;

    sine_quarter_rom #(
        .LUT_AW (LUT_AW),
        .OUT_W  (OUT_W)
    ) u_rom (
        .CLK    (CLK),
        .addr_a (idx2),
        .addr_b (addr_b2),
        .data_a (la3),
        .data_b (lb3)
    );

    always_ff @(posedge CLK) begin
        f3   <= f2;
        neg3 <= neg2;
    end

    assign diff3 = $signed({1'b0, lb3}) - $signed({1'b0, la3});

    always_ff @(posedge CLK) begin
        prod4 <= diff3 * $signed({1'b0, f3});
        la4   <= la3;
        neg4  <= neg3;
    end

    always_comb begin
        mag4    = $signed({1'b0, la4}) + OUT_W'(prod4 >>> FRAC_W);
        y4      = neg4 ? -mag4 : mag4;
        sample4 = OFFSET_BIN ? (y4 ^ (OUT_W'(1) << (OUT_W - 1))) : y4;
    end

endmodule
